// File: rtl/alu_ctrl.sv
// Sequencing controller for an external 8-bit ALU: fetches one instruction,
// drives the ALU for one cycle, then writes the result back to a 4-entry register file.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [8:0] instr,
  output logic       instr_ready,
  output logic [3:0] alu_cmd,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sc_i,
  input  logic [7:0] alu_rslt,
  input  logic       alu_sc_o,
  output logic       done,
  output logic       illegal,
  output logic [2:0] flags,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0] state;
  logic [8:0] instr_q;
  logic [7:0] regs [4];
  logic       carry;
  logic       zero;
  logic       parity;
  logic       illegal_q;

  logic [3:0] op;
  logic [1:0] ra;
  logic       op_illegal;
  logic       op_uses_imm;

  assign op = instr_q[8:5];
  assign ra = instr_q[4:3];

  always_comb begin
    op_illegal  = (op == 4'b0011) || (op == 4'b0100) || (op == 4'b0110);
    op_uses_imm = (op == 4'b0010) || (op == 4'b1011) || (op == 4'b1100);
  end

  // Operands are read in EXEC and the write lands on the closing edge, so ra==rb sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          state     <= S_WB;
          illegal_q <= op_illegal;
          if (!op_illegal) begin
            regs[ra] <= alu_rslt;
            carry    <= alu_sc_o;
            zero     <= (alu_rslt == 8'h00);
            parity   <= ^alu_rslt;
          end
        end
        S_WB: begin
          state     <= S_IDLE;
          illegal_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ALU interface is quiet outside EXEC so the ALU never sees stale operands.
  always_comb begin
    alu_cmd  = 4'd0;
    alu_a    = 8'd0;
    alu_b    = 8'd0;
    alu_sc_i = 1'b0;
    if (state == S_EXEC) begin
      alu_cmd  = op;
      alu_a    = regs[ra];
      alu_b    = op_uses_imm ? {5'd0, instr_q[2:0]} : regs[instr_q[1:0]];
      alu_sc_i = carry;
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign done        = (state == S_WB);
  assign illegal     = (state == S_WB) && illegal_q;
  assign flags       = {carry, zero, parity};
  assign dbg_data    = regs[dbg_sel];

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed testbench for alu_ctrl; a small behavioural ALU answers the controller's requests.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [8:0] instr = '0;
  logic       instr_ready;
  logic [3:0] alu_cmd;
  logic [7:0] alu_a, alu_b;
  logic       alu_sc_i;
  logic [7:0] alu_rslt;
  logic       alu_sc_o;
  logic       done, illegal;
  logic [2:0] flags;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] sr;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .done(done),
    .illegal(illegal), .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Opcodes: 0001 add, 0010 addi, 0101 sub, 1011 sll, 1100 slr, 1101 eq, 1110 lt.
  always_comb begin
    alu_rslt = '0;
    alu_sc_o = 1'b0;
    sr = {alu_a, 8'h00} >> alu_b;
    case (alu_cmd)
      4'b0001, 4'b0010: {alu_sc_o, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0101: {alu_sc_o, alu_rslt} = {1'b0, alu_a} - {1'b0, alu_b};
      4'b1011: {alu_sc_o, alu_rslt} = {1'b0, alu_a} << alu_b;
      4'b1100: begin alu_rslt = sr[15:8]; alu_sc_o = sr[7]; end
      4'b1101: alu_rslt = {7'd0, alu_a == alu_b};
      4'b1110: alu_rslt = {7'd0, alu_a < alu_b};
      default: ;
    endcase
  end

  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers x until the accept edge; returns #1 after it with the DUT in EXEC.
  task automatic send(input logic [8:0] x);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = x;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic exec(input logic [8:0] x);
    send(x);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] sel);
    dbg_sel = sel;
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctl: got ready=%b done=%b illegal=%b want 1 0 0", instr_ready, done, illegal);
    end
    checks++;
    if (flags !== 3'b000 || alu_cmd !== 4'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 || alu_sc_i !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_alu: got flags=%b cmd=%h a=%h b=%h sc=%b want all 0", flags, alu_cmd, alu_a, alu_b, alu_sc_i);
    end
    for (int i = 0; i < 4; i++) begin
      rd(i[1:0]);
      checks++;
      if (dbg_data !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_r%0d: got %h want 00", i, dbg_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    rd(2'd1);
    send(9'b0010_01_101);
    checks++;
    if (instr_ready !== 1'b0 || done !== 1'b0 || alu_cmd !== 4'b0010 || alu_a !== 8'h00 || alu_b !== 8'h05) begin
      errors++;
      $display("[TB] FAIL addi_exec: got ready=%b done=%b cmd=%h a=%h b=%h want 0 0 2 00 05", instr_ready, done, alu_cmd, alu_a, alu_b);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || illegal !== 1'b0 || dbg_data !== 8'h05 || flags !== 3'b000) begin
      errors++;
      $display("[TB] FAIL addi_wb: got done=%b illegal=%b r1=%h flags=%b want 1 0 05 000", done, illegal, dbg_data, flags);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL addi_idle: got done=%b ready=%b want 0 1", done, instr_ready);
    end
  endtask

  task automatic test_add_sub();
    do_reset();
    exec(9'b0010_01_101);
    exec(9'b0010_10_011);
    send(9'b0001_01_110);
    checks++;
    if (alu_a !== 8'h05 || alu_b !== 8'h03) begin
      errors++;
      $display("[TB] FAIL add_operands: got a=%h b=%h want 05 03", alu_a, alu_b);
    end
    @(posedge clk); @(posedge clk); #1;
    rd(2'd1);
    checks++;
    if (dbg_data !== 8'h08 || flags !== 3'b001) begin
      errors++;
      $display("[TB] FAIL add_result: got r1=%h flags=%b want 08 001", dbg_data, flags);
    end
    send(9'b0101_01_001);
    checks++;
    if (alu_a !== 8'h08 || alu_b !== 8'h08) begin
      errors++;
      $display("[TB] FAIL sub_same_reg: got a=%h b=%h want 08 08", alu_a, alu_b);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (dbg_data !== 8'h00 || flags !== 3'b010) begin
      errors++;
      $display("[TB] FAIL sub_result: got r1=%h flags=%b want 00 010", dbg_data, flags);
    end
  endtask

  task automatic test_wrap();
    exec(9'b0010_01_001);
    exec(9'b0101_00_001);
    rd(2'd0);
    checks++;
    if (dbg_data !== 8'hFF || flags !== 3'b100) begin
      errors++;
      $display("[TB] FAIL borrow: got r0=%h flags=%b want ff 100", dbg_data, flags);
    end
    send(9'b0010_00_001);
    checks++;
    if (alu_sc_i !== 1'b1) begin
      errors++;
      $display("[TB] FAIL carry_in: got %b want 1", alu_sc_i);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (dbg_data !== 8'h00 || flags !== 3'b110) begin
      errors++;
      $display("[TB] FAIL wrap: got r0=%h flags=%b want 00 110", dbg_data, flags);
    end
  endtask

  task automatic test_shift();
    do_reset();
    exec(9'b0010_10_101);
    exec(9'b1011_10_011);
    rd(2'd2);
    checks++;
    if (dbg_data !== 8'h28 || flags !== 3'b000) begin
      errors++;
      $display("[TB] FAIL sll: got r2=%h flags=%b want 28 000", dbg_data, flags);
    end
    send(9'b1100_10_100);
    checks++;
    if (alu_b !== 8'h04) begin
      errors++;
      $display("[TB] FAIL slr_imm: got b=%h want 04", alu_b);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (dbg_data !== 8'h02 || flags !== 3'b101) begin
      errors++;
      $display("[TB] FAIL slr: got r2=%h flags=%b want 02 101", dbg_data, flags);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad_ops [3];
    bad_ops = '{4'b0100, 4'b0011, 4'b0110};
    do_reset();
    exec(9'b0010_00_111);
    rd(2'd0);
    for (int i = 0; i < 3; i++) begin
      send({bad_ops[i], 5'b00_000});
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || illegal !== 1'b1) begin
        errors++;
        $display("[TB] FAIL illegal_pulse op=%b: got done=%b illegal=%b want 1 1", bad_ops[i], done, illegal);
      end
      @(posedge clk); #1;
      checks++;
      if (dbg_data !== 8'h07 || flags !== 3'b001 || illegal !== 1'b0) begin
        errors++;
        $display("[TB] FAIL illegal_nowrite op=%b: got r0=%h flags=%b illegal=%b want 07 001 0", bad_ops[i], dbg_data, flags, illegal);
      end
    end
  endtask

  task automatic test_compare();
    do_reset();
    exec(9'b0010_11_100);
    exec(9'b0010_10_100);
    exec(9'b1101_11_010);
    rd(2'd3);
    checks++;
    if (dbg_data !== 8'h01) begin
      errors++;
      $display("[TB] FAIL eq: got r3=%h want 01", dbg_data);
    end
    exec(9'b1110_11_010);
    checks++;
    if (dbg_data !== 8'h01 || flags !== 3'b001) begin
      errors++;
      $display("[TB] FAIL lt: got r3=%h flags=%b want 01 001", dbg_data, flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ready_seen;
    do_reset();
    rd(2'd1);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 9'b0010_01_001;
    @(posedge clk); #1;
    ready_seen[0] = instr_ready;
    instr = 9'b0010_01_010;
    @(posedge clk); #1;
    ready_seen[1] = instr_ready;
    checks++;
    if (ready_seen !== 2'b00 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_busy: got ready=%b done=%b want 00 1", ready_seen, done);
    end
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1 || dbg_data !== 8'h01) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got ready=%b r1=%h want 1 01", instr_ready, dbg_data);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0 || alu_cmd !== 4'b0010 || alu_a !== 8'h01 || alu_b !== 8'h02) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got ready=%b cmd=%h a=%h b=%h want 0 2 01 02", instr_ready, alu_cmd, alu_a, alu_b);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (dbg_data !== 8'h03) begin
      errors++;
      $display("[TB] FAIL b2b_result: got r1=%h want 03", dbg_data);
    end
  endtask

  task automatic test_reset_abort();
    logic done_seen;
    do_reset();
    rd(2'd2);
    send(9'b0010_10_111);
    rst_n = 1'b0;
    #1;
    done_seen = done;
    checks++;
    if (alu_cmd !== 4'd0 || instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_async: got cmd=%h ready=%b want 0 1", alu_cmd, instr_ready);
    end
    @(posedge clk); #1;
    done_seen = done_seen | done;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 9'b0010_11_010;
    rst_n = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0 || alu_cmd !== 4'b0010 || alu_b !== 8'h02) begin
      errors++;
      $display("[TB] FAIL first_edge_accept: got ready=%b cmd=%h b=%h want 0 2 02", instr_ready, alu_cmd, alu_b);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (dbg_data !== 8'h00 || done_seen !== 1'b0 || flags !== 3'b001) begin
      errors++;
      $display("[TB] FAIL abort_nowrite: got r2=%h done_seen=%b flags=%b want 00 0 001", dbg_data, done_seen, flags);
    end
    rd(2'd3);
    checks++;
    if (dbg_data !== 8'h02) begin
      errors++;
      $display("[TB] FAIL post_reset_instr: got r3=%h want 02", dbg_data);
    end
  endtask

  initial begin
    $display("[TB] alu_ctrl directed test start");
    test_reset();
    test_addi();
    test_add_sub();
    test_wrap();
    test_shift();
    test_illegal();
    test_compare();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
